// File: rtl/store_formatter_pkg.sv
// Shared definitions for the store formatter: size codes, lane masks, FSM states
// and the registered write-beat payload.
package store_formatter_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned NLANES = DW / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [NLANES-1:0] MASK_BYTE = 4'b0001;
  localparam logic [NLANES-1:0] MASK_HALF = 4'b0011;
  localparam logic [NLANES-1:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FULL   = 2'b01,
    ST_SPLIT1 = 2'b10,
    ST_SPLIT2 = 2'b11
  } state_e;

  typedef struct packed {
    logic [DW-1:0]     wdata;
    logic [NLANES-1:0] be;
    logic              err;
    logic              last;
  } beat_t;

  // Lane mask for an access size; the reserved code enables no lanes.
  function automatic logic [NLANES-1:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_mask = MASK_BYTE;
      SZ_HALF: size_mask = MASK_HALF;
      SZ_WORD: size_mask = MASK_WORD;
      default: size_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane placement for a store: masks the payload to the access
// size and shifts data and byte enables to the address offset.
// Build option STORE_FORMATTER_SPLIT_UNALIGNED_EN: unaligned halfwords/words are
// legal and lanes that spill past the word are reported as a second beat.
module store_lane_align
  import store_formatter_pkg::*;
(
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic [DW-1:0]     data_i,
  output logic [DW-1:0]     wdata_o,
  output logic [NLANES-1:0] be_o,
  output logic              fault_o,
  output logic              cross_o
`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
  ,
  output logic [DW-1:0]     wdata_hi_o,
  output logic [NLANES-1:0] be_hi_o
`endif
);

  logic [NLANES-1:0]   mask;
  logic [DW-1:0]       data_m;
  logic [4:0]          shamt;
  logic [2*NLANES-1:0] be_sh;

  assign mask  = size_mask(size_i);
  assign shamt = {off_i, 3'b000};
  assign be_sh = {{NLANES{1'b0}}, mask} << off_i;

  // Zero every byte of the register value outside the access size.
  always_comb begin
    data_m = '0;
    for (int i = 0; i < int'(NLANES); i++) begin
      data_m[8*i +: 8] = data_i[8*i +: 8] & {8{mask[i]}};
    end
  end

  assign be_o    = be_sh[NLANES-1:0];
  assign cross_o = |be_sh[2*NLANES-1:NLANES];

`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
  logic [2*DW-1:0] data_sh;

  assign data_sh    = {{DW{1'b0}}, data_m} << shamt;
  assign wdata_o    = data_sh[DW-1:0];
  assign wdata_hi_o = data_sh[2*DW-1:DW];
  assign be_hi_o    = be_sh[2*NLANES-1:NLANES];
  assign fault_o    = (size_i == SZ_RSVD);
`else
  assign wdata_o = data_m << shamt;
  assign fault_o = (size_i == SZ_RSVD)
                 | ((size_i == SZ_HALF) & off_i[0])
                 | ((size_i == SZ_WORD) & (off_i != 2'b00));
`endif

endmodule

// File: rtl/store_formatter.sv
// Store formatter: accepts a store request, registers one lane-placed write
// beat (or a fault beat) and hands it to the memory port with valid/ready.
// Build option STORE_FORMATTER_SPLIT_UNALIGNED_EN: line-crossing stores are
// emitted as two beats through the SPLIT1/SPLIT2 states.
module store_formatter
  import store_formatter_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_addr,
  input  logic [DW-1:0]     in_data,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     out_addr,
  output logic [DW-1:0]     out_wdata,
  output logic [NLANES-1:0] out_be,
  output logic              out_err,
  output logic              out_last
);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [AW-1:0]     addr_q, addr_d;
  beat_t             beat_q, beat_d;
  logic              accept, load;
  logic [DW-1:0]     al_wdata;
  logic [NLANES-1:0] al_be;
  logic              al_fault, al_cross;

`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
  logic [DW-1:0]     al_wdata_hi, hi_wdata_q, hi_wdata_d;
  logic [NLANES-1:0] al_be_hi, hi_be_q, hi_be_d;
`else
  logic              cross_unused;
  assign cross_unused = al_cross;
`endif

  store_lane_align u_align (
    .off_i      (in_addr[1:0]),
    .size_i     (in_size),
    .data_i     (in_data),
    .wdata_o    (al_wdata),
    .be_o       (al_be),
    .fault_o    (al_fault),
    .cross_o    (al_cross)
`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
    ,
    .wdata_hi_o (al_wdata_hi),
    .be_hi_o    (al_be_hi)
`endif
  );

  // Ready when empty, or when the held beat leaves this cycle and is the last one.
  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_FULL) & out_ready);
  assign accept   = in_valid & in_ready;

  // Next-state and next-beat selection.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    load    = 1'b0;
`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
    hi_wdata_d = hi_wdata_q;
    hi_be_d    = hi_be_q;
`endif
    case (state_q)
      ST_IDLE: load = accept;
      ST_FULL: begin
        if (out_ready) begin
          load = accept;
          if (!accept) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
      ST_SPLIT1: begin
        if (out_ready) begin
          state_d     = ST_SPLIT2;
          addr_d      = addr_q + AW'(NLANES);
          beat_d.wdata = hi_wdata_q;
          beat_d.be    = hi_be_q;
          beat_d.last  = 1'b1;
        end
      end
      ST_SPLIT2: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
`endif
      default: ;
    endcase

    if (load) begin
      valid_d = 1'b1;
      state_d = ST_FULL;
      addr_d  = {in_addr[AW-1:2], 2'b00};
      if (al_fault) begin
        beat_d = '{wdata: '0, be: '0, err: 1'b1, last: 1'b1};
      end else begin
        beat_d = '{wdata: al_wdata, be: al_be, err: 1'b0, last: 1'b1};
`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
        if (al_cross) begin
          state_d     = ST_SPLIT1;
          beat_d.last = 1'b0;
          hi_wdata_d  = al_wdata_hi;
          hi_be_d     = al_be_hi;
        end
`endif
      end
    end
  end

  // State and output register; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
      hi_wdata_q <= '0;
      hi_be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
      hi_wdata_q <= hi_wdata_d;
      hi_be_q    <= hi_be_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_wdata = beat_q.wdata;
  assign out_be    = beat_q.be;
  assign out_err   = beat_q.err;
  assign out_last  = beat_q.last;

endmodule

// File: tb/tb_store_formatter.sv
// Directed bench for store_formatter: lane placement, throughput, backpressure,
// faults, reset and (with STORE_FORMATTER_SPLIT_UNALIGNED_EN) two-beat splits.
module tb_store_formatter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        out_err;
  logic        out_last;

  int n_tests = 0;
  int n_fail  = 0;

  store_formatter #(.AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_wdata (out_wdata),
    .out_be    (out_be),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic err, input logic last);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".addr"},  out_addr, a);
    check({tag, ".wdata"}, out_wdata, d);
    check({tag, ".be"},    32'(out_be), 32'(be));
    check({tag, ".err"},   32'(out_err), 32'(err));
    check({tag, ".last"},  32'(out_last), 32'(last));
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 2'b00);

    // Reset state
    step();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.addr",  out_addr, 32'h0);
    check("rst.wdata", out_wdata, 32'h0);
    check("rst.be",    32'(out_be), 32'h0);
    check("rst.err",   32'(out_err), 32'd0);
    check("rst.last",  32'(out_last), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle.in_ready", 32'(in_ready), 32'd1);

    // Byte at 0x1003
    drive(1'b1, 32'h0000_1003, 32'hAABB_CCDD, 2'b00);
    step();
    check_beat("byte", 32'h0000_1000, 32'hDD00_0000, 4'b1000, 1'b0, 1'b1);

    // Halfword at 0x2002, accepted while the byte beat drains
    check("half.in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h0000_2002, 32'h1234_5678, 2'b01);
    step();
    check_beat("half", 32'h0000_2000, 32'h5678_0000, 4'b1100, 1'b0, 1'b1);

    // Four back-to-back words
    for (int i = 0; i < 4; i++) begin
      check("b2b.in_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 32'h0000_3000 + 32'(4 * i), 32'hDEAD_BEEF, 2'b10);
      step();
      check_beat("b2b", 32'h0000_3000 + 32'(4 * i), 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1);
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    step();
    check("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: a word is held while another request waits
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_7000, 32'hCAFE_F00D, 2'b10);
    step();
    drive(1'b1, 32'h0000_7001, 32'h0000_0055, 2'b00);
    for (int i = 0; i < 3; i++) begin
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check_beat("bp.hold", 32'h0000_7000, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    step();
    check_beat("bp.next", 32'h0000_7000, 32'h0000_5500, 4'b0010, 1'b0, 1'b1);

    // Faults
    drive(1'b1, 32'h0000_4001, 32'hFFFF_FFFF, 2'b10);
`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
    drive(1'b1, 32'h0000_4001, 32'hFFFF_FFFF, 2'b11);
`endif
    step();
    check_beat("fault.a", 32'h0000_4000, 32'h0, 4'b0000, 1'b1, 1'b1);
    drive(1'b1, 32'h0000_5000, 32'h1111_1111, 2'b11);
    step();
    check_beat("fault.rsvd", 32'h0000_5000, 32'h0, 4'b0000, 1'b1, 1'b1);
    drive(1'b1, 32'h0000_5001, 32'h1234_5678, 2'b01);
    step();
`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
    check_beat("half.odd", 32'h0000_5000, 32'h0056_7800, 4'b0110, 1'b0, 1'b1);
`else
    check_beat("fault.half", 32'h0000_5000, 32'h0, 4'b0000, 1'b1, 1'b1);
`endif
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    step();
    check("idle2.valid", 32'(out_valid), 32'd0);

`ifdef STORE_FORMATTER_SPLIT_UNALIGNED_EN
    // Split word at offset 3
    drive(1'b1, 32'h0000_6003, 32'h1122_3344, 2'b10);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    check_beat("split.b1", 32'h0000_6000, 32'h4400_0000, 4'b1000, 1'b0, 1'b0);
    check("split.b1.in_ready", 32'(in_ready), 32'd0);
    step();
    check_beat("split.b2", 32'h0000_6004, 32'h0011_2233, 4'b0111, 1'b0, 1'b1);
    check("split.b2.in_ready", 32'(in_ready), 32'd0);
    step();
    check("split.done", 32'(out_valid), 32'd0);

    // Split that wraps the address space
    drive(1'b1, 32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b10);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    check_beat("wrap.b1", 32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100, 1'b0, 1'b0);
    step();
    check_beat("wrap.b2", 32'h0000_0000, 32'h0000_AABB, 4'b0011, 1'b0, 1'b1);
    step();
`endif

    // Reset while a beat is held (first split beat when splitting is built)
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_6003, 32'h1122_3344, 2'b10);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    check("rst2.pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst2.valid", 32'(out_valid), 32'd0);
    check("rst2.be", 32'(out_be), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check("rst2.after1", 32'(out_valid), 32'd0);
    step();
    check("rst2.after2", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
